// File: rtl/lx32_arch_pkg.sv
// Architectural constants of the lx32 ISA shared between fetch, decode and the
// control unit: bit positions of the instruction fields sliced early.
package lx32_arch_pkg;

  localparam int XLEN         = 32;
  localparam int OPCODE_LSB   = 0;
  localparam int OPCODE_MSB   = 6;
  localparam int FUNCT3_LSB   = 12;
  localparam int FUNCT3_MSB   = 14;
  localparam int FUNCT7_5_BIT = 30;

endpackage

// File: rtl/lx32_pkg.sv
// Micro-architectural types of the lx32 core front end.
package lx32_pkg;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_KILL  = 2'd2
  } fetch_state_e;

  localparam logic [31:0] INSTR_BYTES = 32'd4;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small instruction buffer between fetch and decode: synchronous FIFO of
// fetch entries with a flush that wins over push and pop.
module fetch_fifo
  import lx32_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  fetch_entry_t push_entry,
  input  logic         pop,
  input  logic         flush,
  output logic [CW-1:0] count,
  output fetch_entry_t head
);

  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  fetch_entry_t  mem [DEPTH];
  logic          do_push;
  logic          do_pop;

  assign do_push = push && !flush && (count_reg != CW'(DEPTH));
  assign do_pop  = pop && !flush && (count_reg != '0);

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= push_entry;
  end

  assign head  = mem[rd_ptr_reg];
  assign count = count_reg;

endmodule

// File: rtl/fetch_unit.sv
// lx32 instruction fetch: owns the PC, keeps one imem request in flight and
// buffers returned words for decode; an execute redirect squashes everything.
module fetch_unit
  import lx32_pkg::*;
  import lx32_arch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [31:0] dec_instr,
  output logic [31:0] dec_pc,
  output logic [6:0]  dec_opcode,
  output logic [2:0]  dec_funct3,
  output logic        dec_funct7_5
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_e  state_reg, state_next;
  logic [31:0]   pc_reg, pc_next;
  logic [31:0]   pc_req_reg, pc_req_next;
  logic          push;
  logic          req_fire;
  fetch_entry_t  push_entry;
  fetch_entry_t  head;
  logic [CW-1:0] fifo_count;

  assign imem_req_valid = (state_reg == S_FETCH) && (fifo_count < CW'(FIFO_DEPTH))
                          && !redirect_valid && !rst;
  assign imem_req_addr  = pc_reg;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign push_entry     = '{instr: imem_rsp_data, pc: pc_req_reg};

  always_comb begin
    state_next  = state_reg;
    pc_next     = pc_reg;
    pc_req_next = pc_req_reg;
    push        = 1'b0;
    if (redirect_valid) begin
      pc_next = {redirect_pc[31:2], 2'b00};
      // An outstanding request must still drain its response before new issue.
      case (state_reg)
        S_WAIT, S_KILL: state_next = imem_rsp_valid ? S_FETCH : S_KILL;
        default:        state_next = S_FETCH;
      endcase
    end else begin
      case (state_reg)
        S_FETCH: begin
          if (req_fire) begin
            pc_req_next = pc_reg;
            pc_next     = pc_reg + INSTR_BYTES;
            state_next  = S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_rsp_valid) begin
            push       = 1'b1;
            state_next = S_FETCH;
          end
        end
        S_KILL: begin
          if (imem_rsp_valid) state_next = S_FETCH;
        end
        default: state_next = S_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= S_FETCH;
      pc_reg     <= RESET_PC;
      pc_req_reg <= '0;
    end else begin
      state_reg  <= state_next;
      pc_reg     <= pc_next;
      pc_req_reg <= pc_req_next;
    end
  end

  fetch_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_entry(push_entry),
    .pop       (dec_ready),
    .flush     (redirect_valid),
    .count     (fifo_count),
    .head      (head)
  );

  assign dec_valid    = (fifo_count != '0);
  assign dec_instr    = dec_valid ? head.instr : '0;
  assign dec_pc       = dec_valid ? head.pc : '0;
  assign dec_opcode   = dec_instr[OPCODE_MSB:OPCODE_LSB];
  assign dec_funct3   = dec_instr[FUNCT3_MSB:FUNCT3_LSB];
  assign dec_funct7_5 = dec_instr[FUNCT7_5_BIT];

  // A response with nothing outstanding means imem broke the protocol.
  rsp_needs_request: assert property (@(posedge clk) disable iff (rst)
    !(imem_rsp_valid && (state_reg == S_FETCH)));

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: an imem responder with adjustable latency, a queue-based
// model checked every cycle, and directed scenarios with literal expectations.
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam int          DEPTH  = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_instr;
  logic [31:0] dec_pc;
  logic [6:0]  dec_opcode;
  logic [2:0]  dec_funct3;
  logic        dec_funct7_5;

  fetch_unit #(
    .RESET_PC  (RST_PC),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_req_addr (imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .dec_valid     (dec_valid),
    .dec_ready     (dec_ready),
    .dec_instr     (dec_instr),
    .dec_pc        (dec_pc),
    .dec_opcode    (dec_opcode),
    .dec_funct3    (dec_funct3),
    .dec_funct7_5  (dec_funct7_5)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] imem_word(input logic [31:0] a);
    if (a == 32'h0000_0100) return 32'h0050_0093;
    return (a * 32'h0019_660D) ^ 32'h4000_5033;
  endfunction

  // Model state: program counter, buffered {instr,pc} in order, and whether a
  // request is in flight and whether its answer is to be thrown away.
  logic [31:0] m_pc;
  logic [31:0] q_instr[$];
  logic [31:0] q_pc[$];
  bit          m_busy;
  bit          m_drop;
  logic [31:0] m_req_pc;
  int          lat = 1;
  int          cd = 0;
  logic [31:0] rsp_word = 32'h0;

  // Memory side: the answer appears in the cycle whose closing edge is lat edges after the handshake.
  always @(negedge clk) begin
    imem_rsp_valid = (cd == 1);
    imem_rsp_data  = (cd == 1) ? rsp_word : 32'hDEAD_BEEF;
  end

  always @(negedge clk) begin : compare_proc
    bit          ev, erv, hs;
    logic [31:0] ei, epc;
    #2;
    if (rst) begin
      m_pc = RST_PC;
      q_instr.delete();
      q_pc.delete();
      m_busy = 0;
      m_drop = 0;
    end
    ev  = (q_instr.size() != 0);
    ei  = ev ? q_instr[0] : 32'h0;
    epc = ev ? q_pc[0] : 32'h0;
    erv = !rst && !m_busy && (q_instr.size() < DEPTH) && !redirect_valid;
    check("req_valid", {31'b0, imem_req_valid}, {31'b0, erv});
    check("req_addr", imem_req_addr, m_pc);
    check("dec_valid", {31'b0, dec_valid}, {31'b0, ev});
    check("dec_instr", dec_instr, ei);
    check("dec_pc", dec_pc, epc);
    check("dec_opcode", {25'b0, dec_opcode}, ei % 128);
    check("dec_funct3", {29'b0, dec_funct3}, (ei / 4096) % 8);
    check("dec_funct7_5", {31'b0, dec_funct7_5}, (ei / 32'h4000_0000) % 2);
    hs = erv && imem_req_ready;
    if (hs) begin
      cd       = lat;
      rsp_word = imem_word(m_pc);
    end else if (cd > 0) begin
      cd--;
    end
    if (!rst) begin
      if (redirect_valid) begin
        q_instr.delete();
        q_pc.delete();
        m_pc = redirect_pc & 32'hFFFF_FFFC;
        if (m_busy) begin
          if (imem_rsp_valid) m_busy = 0;
          else m_drop = 1;
        end
        $display("redirect -> %h", m_pc);
      end else begin
        if (dec_ready && q_instr.size() != 0) begin
          $display("pop  pc=%h instr=%h", q_pc[0], q_instr[0]);
          void'(q_instr.pop_front());
          void'(q_pc.pop_front());
        end
        if (m_busy && imem_rsp_valid) begin
          if (!m_drop) begin
            q_instr.push_back(imem_rsp_data);
            q_pc.push_back(m_req_pc);
            $display("push pc=%h instr=%h", m_req_pc, imem_rsp_data);
          end else begin
            $display("drop instr=%h", imem_rsp_data);
          end
          m_busy = 0;
          m_drop = 0;
        end
        if (hs) begin
          $display("req  addr=%h", m_pc);
          m_req_pc = m_pc;
          m_pc     = m_pc + 32'd4;
          m_busy   = 1;
          m_drop   = 0;
        end
      end
    end
  end

  // Returns 3 time units after the negedge of the first cycle with a request up.
  task automatic wait_req(input int max_cycles);
    for (int i = 0; i < max_cycles; i++) begin
      @(negedge clk);
      #3;
      if (imem_req_valid) break;
    end
    check("wait_req_bound", {31'b0, imem_req_valid}, 32'd1);
  endtask

  task automatic wait_dec(input int max_cycles);
    for (int i = 0; i < max_cycles; i++) begin
      @(negedge clk);
      #3;
      if (dec_valid) break;
    end
    check("wait_dec_bound", {31'b0, dec_valid}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time %0t, required < 100000", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst            = 1'b1;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    dec_ready      = 1'b0;

    // Reset values, then first fetch at RESET_PC.
    repeat (2) @(negedge clk);
    #3;
    check("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    check("rst_dec_valid", {31'b0, dec_valid}, 32'd0);
    check("rst_req_addr", imem_req_addr, 32'h0000_0100);
    @(negedge clk);
    rst = 1'b0;
    #3;
    check("first_req_valid", {31'b0, imem_req_valid}, 32'd1);
    check("first_req_addr", imem_req_addr, 32'h0000_0100);

    // Backpressure: decode stalled, buffer fills with 0x100 and 0x104.
    repeat (10) @(negedge clk);
    #3;
    check("bp_no_req", {31'b0, imem_req_valid}, 32'd0);
    check("bp_head_pc", dec_pc, 32'h0000_0100);
    check("bp_head_instr", dec_instr, 32'h0050_0093);
    check("bp_head_opcode", {25'b0, dec_opcode}, 32'h13);
    check("bp_head_funct3", {29'b0, dec_funct3}, 32'h0);
    @(negedge clk);
    dec_ready = 1'b1;
    #3;
    check("bp_full_still_no_req", {31'b0, imem_req_valid}, 32'd0);
    @(negedge clk);
    #3;
    check("drain_second_pc", dec_pc, 32'h0000_0104);
    check("resume_req_valid", {31'b0, imem_req_valid}, 32'd1);
    check("resume_req_addr", imem_req_addr, 32'h0000_0108);
    repeat (6) @(negedge clk);

    // Redirect while a slow request is outstanding.
    lat = 3;
    wait_req(20);
    @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0203;
    #3;
    check("redir_blocks_req", {31'b0, imem_req_valid}, 32'd0);
    @(negedge clk);
    redirect_valid = 1'b0;
    #3;
    check("redir_flushed", {31'b0, dec_valid}, 32'd0);
    check("kill_no_req", {31'b0, imem_req_valid}, 32'd0);
    wait_req(20);
    check("redir_target", imem_req_addr, 32'h0000_0200);

    // Redirect in the same cycle as a response, with decode ready.
    @(negedge clk);
    lat       = 1;
    dec_ready = 1'b0;
    wait_req(20);
    @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0300;
    dec_ready      = 1'b1;
    #3;
    check("coin_head_pc", dec_pc, 32'h0000_0200);
    @(negedge clk);
    redirect_valid = 1'b0;
    #3;
    check("coin_flushed", {31'b0, dec_valid}, 32'd0);
    check("coin_req_valid", {31'b0, imem_req_valid}, 32'd1);
    check("coin_target", imem_req_addr, 32'h0000_0300);

    // PC wrap, with the low target bits forced to zero.
    wait_req(20);
    @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFE;
    @(negedge clk);
    redirect_valid = 1'b0;
    #3;
    check("wrap_first_addr", imem_req_addr, 32'hFFFF_FFFC);
    check("wrap_first_valid", {31'b0, imem_req_valid}, 32'd1);
    wait_req(20);
    check("wrap_second_addr", imem_req_addr, 32'h0000_0000);

    // Asynchronous reset with one entry buffered and a request outstanding.
    @(negedge clk);
    lat       = 2;
    dec_ready = 1'b0;
    wait_req(20);
    @(negedge clk);
    #3;
    check("pre_rst_dec_valid", {31'b0, dec_valid}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("async_dec_valid", {31'b0, dec_valid}, 32'd0);
    check("async_req_valid", {31'b0, imem_req_valid}, 32'd0);
    check("async_dec_instr", dec_instr, 32'h0);
    repeat (3) @(negedge clk);
    rst       = 1'b0;
    dec_ready = 1'b1;
    #3;
    check("restart_req_addr", imem_req_addr, 32'h0000_0100);
    check("restart_req_valid", {31'b0, imem_req_valid}, 32'd1);
    wait_dec(20);
    check("restart_head_pc", dec_pc, 32'h0000_0100);
    check("restart_head_instr", dec_instr, 32'h0050_0093);
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
